// File: rtl/vedic_mac_accumulator.sv
// vedic_mac_accumulator: frames products from a fixed-latency, non-stallable multiplier into dot-product sums behind a 2-entry credit-guarded FIFO
//   clk, rst                        clock, async active-high reset
//   issue_valid/issue_last/ready    operand issue handshake (issue = valid & ready)
//   product                         multiplier result, aligned MULT_LATENCY cycles after issue
//   acc_valid/acc_ready             frame result handshake (pop = valid & ready)
//   acc_data/acc_count/acc_overflow FIFO head: frame sum, term count, carry-out seen
//   busy                            tags in flight or partial frame held
module vedic_mac_accumulator #(
  parameter int MULT_LATENCY = 5,
  parameter int PROD_W = 64,
  parameter int ACC_W = 80,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_last,
  output logic              issue_ready,
  input  logic [PROD_W-1:0] product,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_overflow,
  output logic              busy
);
  localparam int LW = $clog2(MULT_LATENCY + 1);
  logic [MULT_LATENCY-1:0] tag_valid, tag_last;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic ovf;
  logic [ACC_W-1:0] fifo_data [2];
  logic [CNT_W-1:0] fifo_cnt [2];
  logic fifo_ovf [2];
  logic rd_ptr, wr_ptr;
  logic [1:0] out_count;
  logic [LW-1:0] lasts;
  logic [ACC_W:0] sum;
  logic issue, arrive, push, pop;
  always_comb begin
    lasts = '0;
    for (int i = 0; i < MULT_LATENCY; i++) lasts = lasts + LW'(tag_valid[i] & tag_last[i]);
  end
  // every last in flight is a guaranteed future push, so it reserves a FIFO slot now
  assign issue_ready = (32'(out_count) + 32'(lasts)) < 32'd2;
  assign issue = issue_valid & issue_ready;
  assign arrive = tag_valid[MULT_LATENCY-1];
  assign push = arrive & tag_last[MULT_LATENCY-1];
  assign pop = acc_valid & acc_ready;
  assign sum = {1'b0, acc} + (ACC_W+1)'(product);
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign acc_valid = out_count != 2'd0;
  assign acc_data = acc_valid ? fifo_data[rd_ptr] : '0;
  assign acc_count = acc_valid ? fifo_cnt[rd_ptr] : '0;
  assign acc_overflow = acc_valid ? fifo_ovf[rd_ptr] : 1'b0;
  assign busy = |tag_valid | (cnt != '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tag_valid <= '0;
      tag_last <= '0;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      out_count <= 2'd0;
    end else begin
      // the low MULT_LATENCY bits of {pipe, new} is a one-place shift that also works for depth 1
      tag_valid <= MULT_LATENCY'({tag_valid, issue});
      tag_last <= MULT_LATENCY'({tag_last, issue & issue_last});
      if (arrive) begin
        acc <= push ? '0 : sum[ACC_W-1:0];
        cnt <= push ? '0 : cnt_inc;
        ovf <= push ? 1'b0 : ovf | sum[ACC_W];
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      out_count <= out_count + {1'b0, push} - {1'b0, pop};
    end
  always_ff @(posedge clk)
    if (push) begin
      fifo_data[wr_ptr] <= sum[ACC_W-1:0];
      fifo_cnt[wr_ptr] <= cnt_inc;
      fifo_ovf[wr_ptr] <= ovf | sum[ACC_W];
    end
endmodule

// File: tb/tb_vedic_mac_accumulator.sv
// tb_vedic_mac_accumulator: scoreboard bench with a behavioural multiplier feeding 80-bit and 64-bit accumulator instances
module tb_vedic_mac_accumulator;
  localparam int L = 5;
  typedef struct packed {
    logic [79:0] d80;
    logic [63:0] d64;
    logic [15:0] c;
    logic o80;
    logic o64;
  } exp_t;
  logic clk = 0, rst = 1, issue_valid = 0, issue_last = 0, acc_ready = 0;
  logic [31:0] a = 0, b = 0;
  logic [63:0] mp [L];
  logic [63:0] product;
  logic issue_ready, acc_valid, acc_overflow, busy;
  logic [79:0] acc_data;
  logic [15:0] acc_count;
  logic issue_ready64, acc_valid64, acc_overflow64, busy64;
  logic [63:0] acc_data64;
  logic [15:0] acc_count64;
  int tests = 0, fails = 0, pops = 0, cyc_n = 0;
  exp_t q[$];
  exp_t e;
  logic [79:0] m80;
  logic [63:0] m64, p;
  logic [80:0] s80;
  logic [64:0] s64;
  logic o80, o64;
  logic [15:0] c;
  int mcnt;

  vedic_mac_accumulator dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_last(issue_last), .issue_ready(issue_ready),
    .product(product), .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
    .acc_count(acc_count), .acc_overflow(acc_overflow), .busy(busy));
  vedic_mac_accumulator #(.ACC_W(64)) dut64 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_last(issue_last), .issue_ready(issue_ready64),
    .product(product), .acc_valid(acc_valid64), .acc_ready(acc_ready), .acc_data(acc_data64),
    .acc_count(acc_count64), .acc_overflow(acc_overflow64), .busy(busy64));

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  always @(posedge clk) begin
    mp[0] <= {32'b0, a} * {32'b0, b};
    for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
  end
  assign product = mp[L-1];

  initial forever begin
    @(negedge clk);
    if (rst) begin
      m80 = '0; m64 = '0; o80 = 0; o64 = 0; mcnt = 0;
      q.delete();
    end else begin
      if ((dut.push && dut.out_count == 2'd2) || (dut64.push && dut64.out_count == 2'd2)) begin
        fails++;
        $display("FAIL push_when_full t=%0t occupancy=%0d required<2", $time, dut.out_count);
      end
      if (acc_valid && acc_ready) begin
        pops++;
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_result got data=%h count=%0d required none", acc_data, acc_count);
        end else begin
          e = q.pop_front();
          if ({acc_data, acc_count, acc_overflow} !== {e.d80, e.c, e.o80}) begin
            fails++;
            $display("FAIL result80 got %h/%0d/%b required %h/%0d/%b", acc_data, acc_count, acc_overflow, e.d80, e.c, e.o80);
          end
          tests++;
          if ({acc_data64, acc_count64, acc_overflow64} !== {e.d64, e.c, e.o64}) begin
            fails++;
            $display("FAIL result64 got %h/%0d/%b required %h/%0d/%b", acc_data64, acc_count64, acc_overflow64, e.d64, e.c, e.o64);
          end
        end
      end
      if (issue_valid && issue_ready) begin
        p = {32'b0, a} * {32'b0, b};
        s80 = {1'b0, m80} + 81'(p);
        s64 = {1'b0, m64} + 65'(p);
        c = (mcnt >= 65535) ? 16'hFFFF : 16'(mcnt + 1);
        if (issue_last) begin
          q.push_back(exp_t'{s80[79:0], s64[63:0], c, o80 | s80[80], o64 | s64[64]});
          m80 = '0; m64 = '0; o80 = 0; o64 = 0; mcnt = 0;
        end else begin
          m80 = s80[79:0]; m64 = s64[63:0]; o80 = o80 | s80[80]; o64 = o64 | s64[64];
          mcnt = mcnt + 1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    issue_valid = 0;
    repeat (n) begin
      a = $urandom; b = $urandom;
      cyc();
    end
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic l);
    int n = 0;
    a = x; b = y; issue_last = l; issue_valid = 1;
    while (!issue_ready && n < 50) begin
      cyc();
      n++;
    end
    if (n == 50) begin
      tests++; fails++;
      $display("FAIL send_timeout got issue_ready=0 for %0d cycles required 1", n);
    end
    cyc();
    issue_valid = 0; issue_last = 0; a = $urandom; b = $urandom;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({acc_valid, acc_data, acc_count, acc_overflow, busy, issue_ready} !== {1'b0, 80'h0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_outputs got v=%b d=%h c=%0d o=%b busy=%b rdy=%b required 0/0/0/0/0/1",
               acc_valid, acc_data, acc_count, acc_overflow, busy, issue_ready);
    end
    repeat (2) cyc();
    rst = 0;
    cyc();
  endtask

  task automatic test_single_term();
    logic early = 0;
    acc_ready = 0;
    send(3, 5, 1);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got %b required 1", busy); end
    for (int k = 1; k <= 5; k++) begin
      early = early | acc_valid;
      cyc();
    end
    tests++;
    if (early !== 1'b0) begin fails++; $display("FAIL single_latency got early acc_valid required none before cycle 6"); end
    tests++;
    if ({acc_valid, acc_data, acc_count, acc_overflow} !== {1'b1, 80'd15, 16'd1, 1'b0}) begin
      fails++;
      $display("FAIL single_result got v=%b d=%0d c=%0d o=%b required 1/15/1/0", acc_valid, acc_data, acc_count, acc_overflow);
    end
    acc_ready = 1;
    idle(2);
    tests++;
    if (acc_valid !== 1'b0) begin fails++; $display("FAIL single_pop got acc_valid=%b required 0", acc_valid); end
  endtask

  task automatic test_four_term();
    int p0 = pops;
    acc_ready = 1;
    send(1, 2, 0); send(3, 4, 0); send(5, 6, 0); send(7, 8, 1);
    idle(8);
    tests++;
    if (pops !== p0 + 1) begin fails++; $display("FAIL four_term_pops got %0d required %0d", pops - p0, 1); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL four_term_busy got %b required 0", busy); end
  endtask

  task automatic test_credit_stall();
    int p0 = pops;
    acc_ready = 0;
    tests++;
    if (issue_ready !== 1'b1) begin fails++; $display("FAIL credit_start got %b required 1", issue_ready); end
    send(2, 3, 1);
    tests++;
    if (issue_ready !== 1'b1) begin fails++; $display("FAIL credit_one got %b required 1", issue_ready); end
    send(4, 5, 1);
    tests++;
    if (issue_ready !== 1'b0) begin fails++; $display("FAIL credit_two got %b required 0", issue_ready); end
    a = 7; b = 7; issue_last = 0; issue_valid = 1;
    repeat (3) cyc();
    issue_valid = 0;
    idle(6);
    tests++;
    if ({issue_ready, acc_valid, acc_data, busy} !== {1'b0, 1'b1, 80'd6, 1'b0}) begin
      fails++;
      $display("FAIL credit_full got rdy=%b v=%b d=%0d busy=%b required 0/1/6/0", issue_ready, acc_valid, acc_data, busy);
    end
    acc_ready = 1;
    idle(2);
    tests++;
    if ({acc_valid, issue_ready} !== 2'b01 || pops !== p0 + 2) begin
      fails++;
      $display("FAIL credit_drain got v=%b rdy=%b pops=%0d required 0/1/2", acc_valid, issue_ready, pops - p0);
    end
  endtask

  task automatic test_overflow();
    acc_ready = 0;
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    send(1, 1, 1);
    idle(7);
    tests++;
    if ({acc_valid64, acc_data64, acc_overflow64} !== {1'b1, 64'hFFFFFFFC00000002, 1'b1}) begin
      fails++;
      $display("FAIL ovf64 got v=%b d=%h o=%b required 1/fffffffc00000002/1", acc_valid64, acc_data64, acc_overflow64);
    end
    tests++;
    if ({acc_data, acc_overflow} !== {80'h1FFFFFFFC00000002, 1'b0}) begin
      fails++;
      $display("FAIL ovf80 got d=%h o=%b required 1fffffffc00000002/0", acc_data, acc_overflow);
    end
    acc_ready = 1;
    cyc();
    tests++;
    if ({acc_valid64, acc_data64, acc_overflow64} !== {1'b1, 64'd1, 1'b0}) begin
      fails++;
      $display("FAIL ovf_next got v=%b d=%h o=%b required 1/1/0", acc_valid64, acc_data64, acc_overflow64);
    end
    idle(3);
  endtask

  task automatic test_push_pop();
    int p0 = pops;
    acc_ready = 0;
    send(9, 9, 1);
    send(11, 11, 1);
    idle(4);
    tests++;
    if ({acc_valid, acc_data} !== {1'b1, 80'd81}) begin
      fails++;
      $display("FAIL pushpop_first got v=%b d=%0d required 1/81", acc_valid, acc_data);
    end
    acc_ready = 1;
    cyc();
    acc_ready = 0;
    tests++;
    if ({acc_valid, acc_data, dut.out_count} !== {1'b1, 80'd121, 2'd1}) begin
      fails++;
      $display("FAIL pushpop_occ got v=%b d=%0d occ=%0d required 1/121/1", acc_valid, acc_data, dut.out_count);
    end
    acc_ready = 1;
    idle(2);
    tests++;
    if (acc_valid !== 1'b0 || pops !== p0 + 2) begin
      fails++;
      $display("FAIL pushpop_drain got v=%b pops=%0d required 0/2", acc_valid, pops - p0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int p0 = pops;
    logic seen = 0;
    acc_ready = 1;
    send(5, 6, 0);
    send(7, 8, 0);
    a = 9; b = 10; issue_last = 1; issue_valid = 1; rst = 1;
    #1;
    tests++;
    if ({busy, acc_valid, issue_ready} !== 3'b001) begin
      fails++;
      $display("FAIL async_reset got busy=%b v=%b rdy=%b required 0/0/1", busy, acc_valid, issue_ready);
    end
    cyc();
    issue_valid = 0; issue_last = 0; rst = 0;
    for (int k = 0; k < 12; k++) begin
      seen = seen | acc_valid | busy;
      idle(1);
    end
    tests++;
    if (seen !== 1'b0 || pops !== p0) begin
      fails++;
      $display("FAIL reset_discard got activity=%b pops=%0d required 0/0", seen, pops - p0);
    end
    send(10, 20, 0);
    send(30, 40, 1);
    idle(8);
    tests++;
    if (pops !== p0 + 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_fresh got pops=%0d busy=%b required 1/0", pops - p0, busy);
    end
  endtask

  task automatic test_back_to_back();
    int p0 = pops;
    int t0;
    acc_ready = 1;
    t0 = cyc_n;
    for (int k = 0; k < 8; k++) send($urandom, $urandom, 0);
    send($urandom, $urandom, 1);
    tests++;
    if (cyc_n - t0 !== 9) begin fails++; $display("FAIL throughput got %0d cycles required 9", cyc_n - t0); end
    for (int f = 0; f < 6; f++) begin
      int n = $urandom_range(1, 4);
      for (int k = 1; k <= n; k++) send($urandom, $urandom, k == n);
    end
    idle(12);
    tests++;
    if (pops !== p0 + 7 || q.size() != 0) begin
      fails++;
      $display("FAIL back_to_back got pops=%0d pending=%0d required 7/0", pops - p0, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_term();
    test_four_term();
    test_credit_stall();
    test_overflow();
    test_push_pop();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
